// File: rtl/adjust_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adjust_pkg
// Brief   : Shared states, output codes and helpers for the adjust key sequencer
// Revision: 1.0
// ============================================================================
package adjust_pkg;

  typedef enum logic [2:0] {
    CLOCK     = 3'd0,
    ALARM     = 3'd1,
    STOPWATCH = 3'd2,
    ADJ_TIME  = 3'd3,
    ADJ_DATE  = 3'd4
  } state_e;

  localparam logic [1:0] MODEL_CLOCK     = 2'b00;
  localparam logic [1:0] MODEL_ALARM     = 2'b01;
  localparam logic [1:0] MODEL_STOPWATCH = 2'b10;
  localparam logic [1:0] MODEL_ADJUST    = 2'b11;

  localparam logic [1:0] SHIF_SEC0  = 2'b00;
  localparam logic [1:0] SHIF_MIN0  = 2'b01;
  localparam logic [1:0] SHIF_HOUR0 = 2'b10;

  localparam int KEY_MODE = 0;
  localparam int KEY_SEL  = 1;
  localparam int KEY_UP   = 2;
  localparam int KEY_DN   = 3;
  localparam int NUM_KEYS = 4;

  // Bits needed to hold 0..max_cnt, never less than one.
  function automatic int cnt_w(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

  function automatic state_e state_next(input state_e s);
    case (s)
      CLOCK:     return ALARM;
      ALARM:     return STOPWATCH;
      STOPWATCH: return ADJ_TIME;
      ADJ_TIME:  return ADJ_DATE;
      default:   return CLOCK;
    endcase
  endfunction

  function automatic logic [1:0] model_of(input state_e s);
    case (s)
      ALARM:              return MODEL_ALARM;
      STOPWATCH:          return MODEL_STOPWATCH;
      ADJ_TIME, ADJ_DATE: return MODEL_ADJUST;
      default:            return MODEL_CLOCK;
    endcase
  endfunction

  function automatic logic is_adj(input state_e s);
    return (s == ALARM) || (s == ADJ_TIME) || (s == ADJ_DATE);
  endfunction

  function automatic logic [1:0] shif_next(input logic [1:0] s);
    case (s)
      SHIF_SEC0: return SHIF_MIN0;
      SHIF_MIN0: return SHIF_HOUR0;
      default:   return SHIF_SEC0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_det.sv
`default_nettype none
// ============================================================================
// Module  : key_press_det
// Brief   : Rising-edge press pulse for one debounced key; optional hold
//           auto-repeat pulse when AUTO_REPEAT_EN is defined
// Revision: 1.0
// ============================================================================
module key_press_det
  import adjust_pkg::*;
`ifdef AUTO_REPEAT_EN
#(
  parameter int RPT_DLY_MS = 500,
  parameter int RPT_PER_MS = 100,
  parameter bit REPEAT     = 1'b0
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic lvl,
  input  logic clr,
  output logic press,
  output logic rpt
);

  logic r_armed;
  logic r_prev;
  logic r_press;

  // r_armed only sets once the key has been seen released, so a key held
  // through reset never produces a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_prev  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_armed <= r_armed | ~lvl;
      r_prev  <= lvl;
      r_press <= r_armed & lvl & ~r_prev;
    end
  end

  assign press = r_press;

  logic w_unused;
  assign w_unused = &{1'b0, tick_ms, clr};

`ifdef AUTO_REPEAT_EN
  generate
    if (REPEAT) begin : g_rpt
      localparam int HOLD_W = cnt_w(RPT_DLY_MS - 1);
      localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RPT_DLY_MS - 1);
      // Assumes RPT_PER_MS <= RPT_DLY_MS; reload leaves RPT_PER_MS ticks to go.
      localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RPT_DLY_MS - RPT_PER_MS);

      logic [HOLD_W-1:0] r_hold;
      logic              r_rpt;
      logic              w_held;

      assign w_held = r_armed & lvl & r_prev & ~clr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hold <= '0;
          r_rpt  <= 1'b0;
        end else begin
          r_rpt <= 1'b0;
          if (!w_held) begin
            r_hold <= '0;
          end else if (tick_ms) begin
            if (r_hold == HOLD_LAST) begin
              r_hold <= HOLD_RELOAD;
              r_rpt  <= 1'b1;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
      end

      assign rpt = r_rpt;
    end else begin : g_no_rpt
      assign rpt = 1'b0;
    end
  endgenerate
`else
  assign rpt = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/adjust_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : adjust_key_ctrl
// Brief   : Front-panel key sequencer: mode FSM, digit select, up/down strobes
//           and inactivity timeout. Optional auto-repeat via AUTO_REPEAT_EN.
// Revision: 1.0
// ============================================================================
module adjust_key_ctrl
  import adjust_pkg::*;
#(
  parameter int TICK_PER_S = 1000,
  parameter int TIMEOUT_S  = 30
`ifdef AUTO_REPEAT_EN
  ,
  parameter int RPT_DLY_MS = 500,
  parameter int RPT_PER_MS = 100
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ms,
  input  logic       key_mode_lvl,
  input  logic       key_sel_lvl,
  input  logic       key_up_lvl,
  input  logic       key_down_lvl,
  output logic [1:0] model,
  output logic       date_time_ch,
  output logic [1:0] adjust_shif,
  output logic       key_up,
  output logic       key_down
);

  localparam int MS_W  = cnt_w(TICK_PER_S - 1);
  localparam int SEC_W = cnt_w(TIMEOUT_S);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TICK_PER_S - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TIMEOUT_S);

  logic [NUM_KEYS-1:0] w_lvl;
  logic [NUM_KEYS-1:0] w_clr;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_rpt;

  state_e           r_state;
  state_e           w_state_nx;
  logic             w_state_chg;
  logic [MS_W-1:0]  r_ms;
  logic [SEC_W-1:0] r_sec;

  assign w_lvl = {key_down_lvl, key_up_lvl, key_sel_lvl, key_mode_lvl};

  // Repeat stops on a state change or while the opposite direction is held.
  assign w_clr[KEY_MODE] = 1'b0;
  assign w_clr[KEY_SEL]  = 1'b0;
  assign w_clr[KEY_UP]   = w_state_chg | key_down_lvl;
  assign w_clr[KEY_DN]   = w_state_chg | key_up_lvl;

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_press_det
`ifdef AUTO_REPEAT_EN
      #(
        .RPT_DLY_MS (RPT_DLY_MS),
        .RPT_PER_MS (RPT_PER_MS),
        .REPEAT     (i >= KEY_UP)
      )
`endif
      u_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_ms (tick_ms),
        .lvl     (w_lvl[i]),
        .clr     (w_clr[i]),
        .press   (w_press[i]),
        .rpt     (w_rpt[i])
      );
    end
  endgenerate

  logic w_mode_p;
  logic w_sel_p;
  logic w_up_ev;
  logic w_dn_ev;
  logic w_any_ev;
  logic w_in_adj;
  logic w_timeout;
  logic w_strobe_ok;

  assign w_mode_p    = w_press[KEY_MODE];
  assign w_sel_p     = w_press[KEY_SEL];
  assign w_up_ev     = w_press[KEY_UP] | w_rpt[KEY_UP];
  assign w_dn_ev     = w_press[KEY_DN] | w_rpt[KEY_DN];
  assign w_any_ev    = |{w_press, w_rpt};
  assign w_in_adj    = is_adj(r_state);
  assign w_timeout   = w_in_adj & (r_sec == SEC_LAST) & ~w_any_ev;
  assign w_strobe_ok = w_in_adj & ~w_mode_p & ~w_sel_p;

  always_comb begin
    w_state_nx = r_state;
    if (w_mode_p) begin
      w_state_nx = state_next(r_state);
    end else if (w_timeout) begin
      w_state_nx = CLOCK;
    end
  end

  assign w_state_chg = (w_state_nx != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CLOCK;
      model        <= MODEL_CLOCK;
      date_time_ch <= 1'b0;
      adjust_shif  <= SHIF_SEC0;
      key_up       <= 1'b0;
      key_down     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      model        <= model_of(w_state_nx);
      date_time_ch <= (w_state_nx == ADJ_DATE);
      if (w_state_chg) begin
        adjust_shif <= SHIF_SEC0;
      end else if (w_sel_p && w_in_adj) begin
        adjust_shif <= shif_next(adjust_shif);
      end
      key_up   <= w_strobe_ok & w_up_ev & ~w_dn_ev;
      key_down <= w_strobe_ok & w_dn_ev & ~w_up_ev;
    end
  end

  // Inactivity timer runs only in the editable modes; any key activity restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ms  <= '0;
      r_sec <= '0;
    end else if (!w_in_adj || w_any_ev || w_state_chg) begin
      r_ms  <= '0;
      r_sec <= '0;
    end else if (tick_ms) begin
      if (r_ms == MS_LAST) begin
        r_ms <= '0;
        if (r_sec != SEC_LAST) begin
          r_sec <= r_sec + 1'b1;
        end
      end else begin
        r_ms <= r_ms + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adjust_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_adjust_key_ctrl
// Brief   : Directed self-checking bench for adjust_key_ctrl
// Revision: 1.0
// ============================================================================
module tb_adjust_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_ms = 1'b0;
  logic       key_mode_lvl = 1'b0;
  logic       key_sel_lvl = 1'b0;
  logic       key_up_lvl = 1'b0;
  logic       key_down_lvl = 1'b0;
  logic [1:0] model;
  logic       date_time_ch;
  logic [1:0] adjust_shif;
  logic       key_up;
  logic       key_down;

  int n_chk  = 0;
  int n_fail = 0;
  int n_up   = 0;
  int n_dn   = 0;
  int n_both = 0;

  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_SEL  = 4'b0010;
  localparam logic [3:0] K_UP   = 4'b0100;
  localparam logic [3:0] K_DN   = 4'b1000;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_STROBES = 4;
`else
  localparam int RPT_STROBES = 1;
`endif

  int exp_m [5] = '{1, 2, 3, 3, 0};
  int exp_d [5] = '{0, 0, 0, 1, 0};
  int exp_s [5] = '{1, 0, 1, 1, 0};
  int exp_sel [4] = '{1, 2, 0, 1};

  always #5 clk = ~clk;

  adjust_key_ctrl #(
    .TICK_PER_S (4),
    .TIMEOUT_S  (2)
`ifdef AUTO_REPEAT_EN
    ,
    .RPT_DLY_MS (5),
    .RPT_PER_MS (2)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_ms      (tick_ms),
    .key_mode_lvl (key_mode_lvl),
    .key_sel_lvl  (key_sel_lvl),
    .key_up_lvl   (key_up_lvl),
    .key_down_lvl (key_down_lvl),
    .model        (model),
    .date_time_ch (date_time_ch),
    .adjust_shif  (adjust_shif),
    .key_up       (key_up),
    .key_down     (key_down)
  );

  // Strobe high-cycle counters: a clean 1-cycle strobe adds exactly one.
  always @(negedge clk) begin
    if (key_up)              n_up   <= n_up + 1;
    if (key_down)            n_dn   <= n_dn + 1;
    if (key_up && key_down)  n_both <= n_both + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int m, input int d, input int s);
    chk({tag, "_model"}, int'(model), m);
    chk({tag, "_dtc"}, int'(date_time_ch), d);
    chk({tag, "_shif"}, int'(adjust_shif), s);
  endtask

  task automatic press(input logic [3:0] k);
    {key_down_lvl, key_up_lvl, key_sel_lvl, key_mode_lvl} = k;
    cyc(4);
    {key_down_lvl, key_up_lvl, key_sel_lvl, key_mode_lvl} = 4'b0000;
    cyc(4);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      tick_ms = 1'b1;
      cyc(1);
      tick_ms = 1'b0;
      cyc(2);
    end
  endtask

  initial begin
    int base;

    // Reset with up key held, then release reset: no strobe may result.
    key_up_lvl = 1'b1;
    cyc(3);
    chk_state("rst", 0, 0, 0);
    chk("rst_key_up", int'(key_up), 0);
    chk("rst_key_down", int'(key_down), 0);
    rst_n = 1'b1;
    cyc(6);
    chk("held_through_reset_up", n_up, 0);
    key_up_lvl = 1'b0;
    cyc(4);
    chk("held_release_up", n_up, 0);
    chk_state("post_rst", 0, 0, 0);

    // Full mode cycle; a sel after each step shows where it is honoured and
    // that the following mode press clears adjust_shif.
    for (int i = 0; i < 5; i++) begin
      press(K_MODE);
      chk_state("mode_step", exp_m[i], exp_d[i], 0);
      press(K_SEL);
      chk("sel_after_mode", int'(adjust_shif), exp_s[i]);
    end
    chk("mode_cycle_no_up", n_up, 0);
    chk("mode_cycle_no_dn", n_dn, 0);

    // ADJ_TIME: digit select wrap, then one up and one down press.
    repeat (3) press(K_MODE);
    chk_state("adj_time", 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      press(K_SEL);
      chk("sel_step", int'(adjust_shif), exp_sel[i]);
    end
    press(K_UP);
    chk("adj_up_one", n_up, 1);
    chk("adj_up_no_dn", n_dn, 0);
    press(K_DN);
    chk("adj_dn_one", n_dn, 1);
    chk("adj_dn_no_up", n_up, 1);

    // ADJ_DATE timeout: 7 ticks stay, the 8th returns to CLOCK.
    press(K_MODE);
    chk_state("adj_date", 3, 1, 0);
    press(K_SEL);
    press(K_SEL);
    chk("date_shif", int'(adjust_shif), 2);
    tick(7);
    chk_state("to_tick7", 3, 1, 2);
    tick(1);
    chk_state("to_tick8", 0, 0, 0);

    // A press after 6 ticks restarts the timeout count.
    repeat (4) press(K_MODE);
    press(K_SEL);
    press(K_SEL);
    chk_state("adj_date2", 3, 1, 2);
    tick(6);
    press(K_UP);
    chk("restart_up", n_up, 2);
    tick(2);
    chk_state("restart_tick8", 3, 1, 2);
    tick(5);
    chk_state("restart_7_after", 3, 1, 2);
    tick(1);
    chk_state("restart_8_after", 0, 0, 0);

    // STOPWATCH drops up; ALARM drops up+down together; mode beats up.
    press(K_MODE);
    press(K_MODE);
    chk("stopwatch", int'(model), 2);
    press(K_UP);
    chk("stopwatch_no_up", n_up, 2);
    repeat (4) press(K_MODE);
    chk("alarm", int'(model), 1);
    press(K_UP | K_DN);
    chk("both_no_up", n_up, 2);
    chk("both_no_dn", n_dn, 1);
    press(K_MODE | K_UP);
    chk("mode_up_model", int'(model), 2);
    chk("mode_up_no_up", n_up, 2);

    // Down held 10 ms in ALARM.
    repeat (4) press(K_MODE);
    chk("alarm_rpt", int'(model), 1);
    base = n_dn;
    key_down_lvl = 1'b1;
    cyc(4);
    tick(10);
    chk("hold_dn_strobes", n_dn - base, RPT_STROBES);
    key_down_lvl = 1'b0;
    cyc(4);
    tick(3);
    chk("release_dn_strobes", n_dn - base, RPT_STROBES);
    chk("never_both", n_both, 0);
    chk("hold_no_up", n_up, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
